// File: rtl/ram_bist_pkg.sv
// Shared encodings for the RAM write/read-back BIST controller.
package ram_bist_pkg;

    // Data pattern selected at start
    typedef enum logic [1:0] {
        MODE_INC  = 2'd0,
        MODE_INV  = 2'd1,
        MODE_CHK  = 2'd2,
        MODE_WALK = 2'd3
    } bist_mode_e;

    // Controller phases
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } bist_state_e;

endpackage

// File: rtl/ram_bist_pattern.sv
// Combinational pattern generator: data word for a given mode and address.
module ram_bist_pattern
    import ram_bist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] inc_pat, chk_pat, walk_pat;
    int unsigned       sh;

    // Build every candidate pattern, then pick one by mode
    always_comb begin
        inc_pat = DATA_W'(addr);
        for (int i = 0; i < DATA_W; i++) begin
            // even bits set on even addresses (0x55..), odd bits on odd (0xAA..)
            chk_pat[i] = addr[0] ^ (i % 2 == 0);
        end
        sh       = 32'(addr) % DATA_W;
        walk_pat = DATA_W'(1) << sh;
        case (bist_mode_e'(mode))
            MODE_INC:  data = inc_pat;
            MODE_INV:  data = ~inc_pat;
            MODE_CHK:  data = chk_pat;
            MODE_WALK: data = walk_pat;
            default:   data = inc_pat;
        endcase
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// Write/read-back BIST controller for a simple dual-port RAM.
// Port A fills DEPTH words with a pattern, port B reads them back and the
// returned data is compared against the pattern carried down a pipeline
// matched to the RAM read latency.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              ram_en_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_en_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    input  logic [DATA_W-1:0] ram_rd_data_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    // One extra counter bit so DEPTH == 2**ADDR_W never aliases to zero
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    bist_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        mode_q;
    logic              cnt_last, accept, wr_issue, rd_issue, finish, mismatch;
    logic [ADDR_W-1:0] cnt_addr, addr_a_q, addr_b_q;
    logic [DATA_W-1:0] pat_a, pat_b, wr_data_q;

    // Stage k holds a read issued k cycles ago; stage RD_LAT meets its data
    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][DATA_W-1:0] exp_pipe;
    logic [RD_LAT:1][ADDR_W-1:0] adr_pipe;

    assign cnt_last = (cnt_q == CNT_LAST);
    assign cnt_addr = cnt_q[ADDR_W-1:0];

    ram_bist_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pat_a (
        .mode (mode_q),
        .addr (cnt_addr),
        .data (pat_a)
    );

    ram_bist_pattern #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pat_b (
        .mode (mode_q),
        .addr (cnt_addr),
        .data (pat_b)
    );

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state and per-cycle issue decode
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        wr_issue = 1'b0;
        rd_issue = 1'b0;
        finish   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_issue = 1'b1;
                if (cnt_last) state_d = S_READ;
            end
            S_READ: begin
                rd_issue = 1'b1;
                if (cnt_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (vld_pipe == '0) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address counter and mode capture on accepted start
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= '0;
            mode_q <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            mode_q <= mode;
        end else if (wr_issue || rd_issue) begin
            cnt_q  <= cnt_last ? '0 : cnt_q + CNT_ONE;
        end
    end

    // Port outputs follow the counter while active and hold their last value otherwise
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_a_q  <= '0;
            wr_data_q <= '0;
            addr_b_q  <= '0;
        end else begin
            if (wr_issue) begin
                addr_a_q  <= cnt_addr;
                wr_data_q <= pat_a;
            end
            if (rd_issue) addr_b_q <= cnt_addr;
        end
    end

    assign ram_en_a    = wr_issue;
    assign ram_we_a    = wr_issue;
    assign ram_addr_a  = wr_issue ? cnt_addr : addr_a_q;
    assign ram_wr_data = wr_issue ? pat_a    : wr_data_q;
    assign ram_en_b    = rd_issue;
    assign ram_addr_b  = rd_issue ? cnt_addr : addr_b_q;
    assign busy        = (state_q != S_IDLE);

    // Expected-data pipeline, aligned to the RAM read latency
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_pipe <= '0;
            exp_pipe <= '0;
            adr_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_issue;
            exp_pipe[1] <= pat_b;
            adr_pipe[1] <= cnt_addr;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                exp_pipe[k] <= exp_pipe[k-1];
                adr_pipe[k] <= adr_pipe[k-1];
            end
        end
    end

    assign mismatch = vld_pipe[RD_LAT] && (ram_rd_data_b != exp_pipe[RD_LAT]);

    // Result tracking: saturating error count, first failing address, pass/done
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                err_cnt        <= '0;
                first_err_addr <= '0;
                pass           <= 1'b0;
            end else if (mismatch) begin
                if (err_cnt == '0) first_err_addr <= adr_pipe[RD_LAT];
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
            end
            // the drain guarantees the last compare has already landed in err_cnt
            if (finish) pass <= (err_cnt == '0);
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (default and 16b/4b/16/3 sweep),
// each attached to a behavioural 2-port RAM with per-address stuck-bit faults.
module tb_ram_bist_ctrl;

    localparam int DW0 = 8,  AW0 = 6, D0 = 64, L0 = 1;
    localparam int DW1 = 16, AW1 = 4, D1 = 16, L1 = 3;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // instance 0 signals
    logic           start0, en_a0, we_a0, en_b0, busy0, done0, pass0;
    logic [1:0]     mode0;
    logic [AW0-1:0] addr_a0, addr_b0, ferr0;
    logic [DW0-1:0] wr_data0, rd_data0;
    logic [AW0:0]   err_cnt0;
    // instance 1 signals
    logic           start1, en_a1, we_a1, en_b1, busy1, done1, pass1;
    logic [1:0]     mode1;
    logic [AW1-1:0] addr_a1, addr_b1, ferr1;
    logic [DW1-1:0] wr_data1, rd_data1;
    logic [AW1:0]   err_cnt1;

    ram_bist_ctrl #(.DATA_W(DW0), .ADDR_W(AW0), .DEPTH(D0), .RD_LAT(L0)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start0), .mode(mode0),
        .ram_en_a(en_a0), .ram_we_a(we_a0), .ram_addr_a(addr_a0), .ram_wr_data(wr_data0),
        .ram_en_b(en_b0), .ram_addr_b(addr_b0), .ram_rd_data_b(rd_data0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0), .first_err_addr(ferr0)
    );

    ram_bist_ctrl #(.DATA_W(DW1), .ADDR_W(AW1), .DEPTH(D1), .RD_LAT(L1)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start1), .mode(mode1),
        .ram_en_a(en_a1), .ram_we_a(we_a1), .ram_addr_a(addr_a1), .ram_wr_data(wr_data1),
        .ram_en_b(en_b1), .ram_addr_b(addr_b1), .ram_rd_data_b(rd_data1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1), .first_err_addr(ferr1)
    );

    // ---------------- behavioural RAMs with fault hook ----------------
    logic [DW0-1:0] mem0 [D0];
    logic [DW0-1:0] rp0  [L0];
    bit             flt_en0  [D0];
    int             flt_bit0 [D0];
    bit             flt_val0 [D0];
    logic [DW1-1:0] mem1 [D1];
    logic [DW1-1:0] rp1  [L1];
    bit             flt_en1  [D1];
    int             flt_bit1 [D1];
    bit             flt_val1 [D1];

    function automatic logic [DW0-1:0] rd0(input int a);
        logic [DW0-1:0] v;
        v = mem0[a];
        if (flt_en0[a]) v[flt_bit0[a]] = flt_val0[a];
        return v;
    endfunction

    function automatic logic [DW1-1:0] rd1(input int a);
        logic [DW1-1:0] v;
        v = mem1[a];
        if (flt_en1[a]) v[flt_bit1[a]] = flt_val1[a];
        return v;
    endfunction

    always @(posedge sys_clk) begin
        if (en_a0 && we_a0) mem0[addr_a0] <= wr_data0;
        if (en_b0) rp0[0] <= rd0(int'(addr_b0));
        for (int k = 1; k < L0; k++) rp0[k] <= rp0[k-1];
    end
    assign rd_data0 = rp0[L0-1];

    always @(posedge sys_clk) begin
        if (en_a1 && we_a1) mem1[addr_a1] <= wr_data1;
        if (en_b1) rp1[0] <= rd1(int'(addr_b1));
        for (int k = 1; k < L1; k++) rp1[k] <= rp1[k-1];
    end
    assign rd_data1 = rp1[L1-1];

    // activity counters sampled mid-cycle
    int dn0 = 0, wr0 = 0, rdc0 = 0, dn1 = 0, wr1 = 0, rdc1 = 0;
    always @(negedge sys_clk) begin
        if (done0)          dn0  <= dn0 + 1;
        if (en_a0 && we_a0) wr0  <= wr0 + 1;
        if (en_b0)          rdc0 <= rdc0 + 1;
        if (done1)          dn1  <= dn1 + 1;
        if (en_a1 && we_a1) wr1  <= wr1 + 1;
        if (en_b1)          rdc1 <= rdc1 + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] pat(input int mode, input int a, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        case (mode)
            0:       return 64'(a) & m;
            1:       return ~64'(a) & m;
            2:       return ((a % 2) == 0 ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA) & m;
            default: return 64'd1 << (a % w);
        endcase
    endfunction

    task automatic predict(input int sel, input int mode, output int e, output int f);
        int d, w, emax;
        logic [63:0] p, r;
        d    = (sel != 0) ? D1 : D0;
        w    = (sel != 0) ? DW1 : DW0;
        emax = (sel != 0) ? (1 << (AW1 + 1)) - 1 : (1 << (AW0 + 1)) - 1;
        e = 0;
        f = 0;
        for (int a = 0; a < d; a++) begin
            p = pat(mode, a, w);
            r = p;
            if (sel == 0 && flt_en0[a]) r[flt_bit0[a]] = flt_val0[a];
            if (sel != 0 && flt_en1[a]) r[flt_bit1[a]] = flt_val1[a];
            if (r != p) begin
                if (e == 0) f = a;
                e++;
            end
        end
        if (e > emax) e = emax;
    endtask

    function automatic int mem_bad(input int sel, input int mode);
        int n;
        n = 0;
        if (sel == 0) begin
            for (int a = 0; a < D0; a++) if (64'(mem0[a]) !== pat(mode, a, DW0)) n++;
        end else begin
            for (int a = 0; a < D1; a++) if (64'(mem1[a]) !== pat(mode, a, DW1)) n++;
        end
        return n;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_faults();
        for (int a = 0; a < D0; a++) flt_en0[a] = 1'b0;
        for (int a = 0; a < D1; a++) flt_en1[a] = 1'b0;
    endtask

    task automatic add_fault(input int sel, input int a, input int b, input bit v);
        if (sel == 0) begin flt_en0[a] = 1'b1; flt_bit0[a] = b; flt_val0[a] = v; end
        else          begin flt_en1[a] = 1'b1; flt_bit1[a] = b; flt_val1[a] = v; end
    endtask

    task automatic drive(input int sel, input bit s, input logic [1:0] m);
        if (sel == 0) begin start0 = s; mode0 = m; end
        else          begin start1 = s; mode1 = m; end
    endtask

    function automatic bit done_of(input int sel); return (sel != 0) ? done1 : done0; endfunction
    function automatic bit busy_of(input int sel); return (sel != 0) ? busy1 : busy0; endfunction
    function automatic bit pass_of(input int sel); return (sel != 0) ? pass1 : pass0; endfunction
    function automatic int err_of (input int sel); return (sel != 0) ? int'(err_cnt1) : int'(err_cnt0); endfunction
    function automatic int ferr_of(input int sel); return (sel != 0) ? int'(ferr1) : int'(ferr0); endfunction

    function automatic bit outs_zero(input int sel);
        if (sel == 0)
            return {en_a0, we_a0, addr_a0, wr_data0, en_b0, addr_b0, busy0, done0, pass0, err_cnt0, ferr0} === '0;
        return {en_a1, we_a1, addr_a1, wr_data1, en_b1, addr_b1, busy1, done1, pass1, err_cnt1, ferr1} === '0;
    endfunction

    // One pass: start sampled at edge E0; lat = edges after E0 until done seen (-1 on timeout)
    task automatic run_pass(input int sel, input logic [1:0] mode, input bit disturb,
                            output int lat, output bit busy_ok);
        int d;
        d       = (sel != 0) ? D1 : D0;
        lat     = -1;
        @(posedge sys_clk); #1;
        drive(sel, 1'b1, mode);
        @(posedge sys_clk); #1;
        drive(sel, 1'b0, mode);
        busy_ok = busy_of(sel);
        for (int n = 1; n <= 4 * d + 20; n++) begin
            if (disturb) begin
                if (n == 10)        drive(sel, 1'b1, ~mode);
                if (n == 11)        drive(sel, 1'b0, ~mode);
                if (n == 2 * d + 1) drive(sel, 1'b1, mode);
                if (n == 2 * d + 2) drive(sel, 1'b0, mode);
            end
            @(posedge sys_clk); #1;
            if (done_of(sel)) begin
                lat = n;
                break;
            end
        end
        drive(sel, 1'b0, mode);
    endtask

    task automatic run_check(input int sel, input logic [1:0] mode, input bit disturb, input string tag);
        int lat, e, f, d, l, dn_b, wr_b, rd_b;
        bit bz;
        d    = (sel != 0) ? D1 : D0;
        l    = (sel != 0) ? L1 : L0;
        dn_b = (sel != 0) ? dn1 : dn0;
        wr_b = (sel != 0) ? wr1 : wr0;
        rd_b = (sel != 0) ? rdc1 : rdc0;
        run_pass(sel, mode, disturb, lat, bz);
        predict(sel, int'(mode), e, f);
        chk({tag, ".latency"},    64'(lat), 64'(2 * d + l + 1));
        chk({tag, ".busy_start"}, bz, 1);
        chk({tag, ".busy_done"},  busy_of(sel), 0);
        chk({tag, ".pass"},       pass_of(sel), (e == 0));
        chk({tag, ".err_cnt"},    err_of(sel), e);
        chk({tag, ".first_err"},  ferr_of(sel), f);
        chk({tag, ".wr_data"},    mem_bad(sel, int'(mode)), 0);
        @(posedge sys_clk); #1;
        chk({tag, ".done_1cyc"},  done_of(sel), 0);
        repeat (4) @(posedge sys_clk);
        #1;
        chk({tag, ".n_done"},   ((sel != 0) ? dn1  : dn0)  - dn_b, 1);
        chk({tag, ".n_writes"}, ((sel != 0) ? wr1  : wr0)  - wr_b, d);
        chk({tag, ".n_reads"},  ((sel != 0) ? rdc1 : rdc0) - rd_b, d);
    endtask

    task automatic random_faults(input int sel);
        int d, w, nf;
        d  = (sel != 0) ? D1 : D0;
        w  = (sel != 0) ? DW1 : DW0;
        nf = $urandom_range(0, 3);
        clr_faults();
        for (int i = 0; i < nf; i++)
            add_fault(sel, $urandom_range(0, d - 1), $urandom_range(0, w - 1), 1'($urandom_range(0, 1)));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int dn_b;
        logic [1:0] m;
        start0 = 1'b0; mode0 = '0;
        start1 = 1'b0; mode1 = '0;
        clr_faults();
        for (int a = 0; a < D0; a++) mem0[a] = '0;
        for (int a = 0; a < D1; a++) mem1[a] = '0;

        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset.outs0", outs_zero(0), 1);
        chk("reset.outs1", outs_zero(1), 1);
        sys_rst_n = 1'b1;

        // incrementing pattern, clean RAM
        run_check(0, 2'd0, 1'b0, "t1_inc");
        chk("t1.addr_a_hold", addr_a0, 63);
        chk("t1.mem63", mem0[63], 8'd63);

        // checkerboard and walking one
        run_check(0, 2'd2, 1'b0, "t2_chk");
        chk("t2.mem0", mem0[0], 8'h55);
        chk("t2.mem1", mem0[1], 8'hAA);
        run_check(0, 2'd3, 1'b0, "t2_walk");
        chk("t2.mem9", mem0[9], 8'h02);

        // stuck bit 3 at addresses 5 and 40
        add_fault(0, 5, 3, 1'b1);
        add_fault(0, 40, 3, 1'b0);
        run_check(0, 2'd0, 1'b0, "t3_stuck");
        chk("t3.err_cnt", err_cnt0, 2);
        chk("t3.first_err", ferr0, 5);
        chk("t3.pass", pass0, 0);

        // stray starts and mode toggle while busy
        add_fault(0, 17, 0, 1'b1);
        run_check(0, 2'd1, 1'b1, "t4_disturb");
        run_check(0, 2'd0, 1'b1, "t4_disturb_inc");

        // reset in the middle of the write phase
        clr_faults();
        @(posedge sys_clk); #1;
        drive(0, 1'b1, 2'd0);
        @(posedge sys_clk); #1;
        drive(0, 1'b0, 2'd0);
        repeat (19) @(posedge sys_clk);
        #1;
        chk("t5.wr_addr19", addr_a0, 19);
        dn_b = dn0;
        sys_rst_n = 1'b0;
        #1;
        chk("t5.outs0_rst", outs_zero(0), 1);
        repeat (3) @(posedge sys_clk);
        #1;
        chk("t5.outs0_rst_hold", outs_zero(0), 1);
        chk("t5.outs1_rst_hold", outs_zero(1), 1);
        sys_rst_n = 1'b1;
        repeat (2 * D0 + 10) @(posedge sys_clk);
        #1;
        chk("t5.no_done", dn0 - dn_b, 0);
        chk("t5.idle", busy0, 0);
        run_check(0, 2'd0, 1'b0, "t5_after");

        // random modes and faults on the default instance
        for (int r = 0; r < 6; r++) begin
            random_faults(0);
            m = 2'($urandom_range(0, 3));
            run_check(0, m, 1'($urandom_range(0, 1)), "rnd0");
        end

        // parameter sweep instance
        clr_faults();
        run_check(1, 2'd0, 1'b0, "t6_inc");
        chk("t6.addr_a_wrap", addr_a1, 15);
        chk("t6.addr_b_wrap", addr_b1, 15);
        chk("t6.mem15", mem1[15], 16'h000F);
        run_check(1, 2'd3, 1'b0, "t6_walk");
        chk("t6.mem15_walk", mem1[15], 16'h8000);
        run_check(1, 2'd2, 1'b0, "t6_chk");
        chk("t6.mem0_chk", mem1[0], 16'h5555);
        for (int r = 0; r < 4; r++) begin
            random_faults(1);
            m = 2'($urandom_range(0, 3));
            run_check(1, m, 1'b0, "rnd1");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
